// File: rtl/pwm_demod_pkg.sv
// Shared DDS definitions for the PWM demodulator.
//
// Contents:
//   DDS_N, DDS_M   - default frame exponent and duty width, shared with the phase
//                    accumulator and the PWM modulator
//   ST_SYNC/ST_RUN - state encoding constants
//   demod_state_e  - demodulator state type built on those constants
//   DUTY_FULL      - all-ones duty word at the default width

package pwm_demod_pkg;

    localparam int unsigned DDS_N = 14;
    localparam int unsigned DDS_M = 12;

    localparam logic ST_SYNC = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef enum logic {
        StSync = ST_SYNC,
        StRun  = ST_RUN
    } demod_state_e;

    localparam logic [DDS_M-1:0] DUTY_FULL = {DDS_M{1'b1}};

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchronizer and rising-edge detector for an asynchronous 1-bit input.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   din    in   asynchronous input
//   level  out  synchronized (optionally filtered) level
//   rise   out  one-cycle pulse on a 0->1 transition of level
//
// Optional: define PWM_DEMOD_GLITCH_FILTER_EN to add a 3-sample majority
// filter after the synchronizer. It rejects single-cycle pulses and dropouts
// at the cost of 2 extra clocks of latency.

module pwm_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
        end
    end

`ifdef PWM_DEMOD_GLITCH_FILTER_EN
    logic h1_q;
    logic h2_q;
    logic f_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1_q <= 1'b0;
            h2_q <= 1'b0;
            f_q  <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            h1_q <= s2_q;
            h2_q <= h1_q;
            // Majority of the three most recent samples.
            f_q  <= (s2_q & h1_q) | (s2_q & h2_q) | (h1_q & h2_q);
            s3_q <= f_q;
        end
    end

    assign level = f_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_q <= 1'b0;
        end else begin
            s3_q <= s2_q;
        end
    end

    assign level = s2_q;
`endif

    assign rise = level & ~s3_q;

endmodule

// File: rtl/pwm_demod.sv
// PWM demodulator: measures the high time of a 1-bit PWM stream over frames of
// 2^N clocks and returns the M-bit duty word that produced it.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   en          in   measurement enable; low forces the SYNC state
//   pwm_in      in   PWM stream, asynchronous to clk
//   duty        out  last completed frame's duty word (M bits)
//   duty_valid  out  one-cycle strobe when duty updates
//   locked      out  frames are aligned to a rising edge
//   stuck       out  last completed frame had no rising edge
//
// Optional: PWM_DEMOD_GLITCH_FILTER_EN enables the majority glitch filter in
// pwm_sync_edge.

module pwm_demod
    import pwm_demod_pkg::*;
#(
    parameter int unsigned N = DDS_N,
    parameter int unsigned M = DDS_M
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         pwm_in,
    output logic [M-1:0] duty,
    output logic         duty_valid,
    output logic         locked,
    output logic         stuck
);

    logic level;
    logic rise;

    pwm_sync_edge u_sync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (pwm_in),
        .level (level),
        .rise  (rise)
    );

    demod_state_e   state_q, state_d;
    logic [N-1:0]   frame_cnt_q, frame_cnt_d;
    logic [N:0]     high_cnt_q, high_cnt_d;
    logic           rise_seen_q, rise_seen_d;
    logic [M-1:0]   duty_q, duty_d;
    logic           valid_q, valid_d;
    logic           locked_q, locked_d;
    logic           stuck_q, stuck_d;

    logic [N:0]     level_ext;
    assign level_ext = {{N{1'b0}}, level};

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        high_cnt_d  = high_cnt_q;
        rise_seen_d = rise_seen_q;
        duty_d      = duty_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        stuck_d     = stuck_q;

        if (!en) begin
            // Enable wins over everything, including a frame end.
            state_d     = StSync;
            locked_d    = 1'b0;
            frame_cnt_d = '0;
            high_cnt_d  = '0;
            rise_seen_d = 1'b0;
        end else begin
            unique case (state_q)
                StSync: begin
                    frame_cnt_d = '0;
                    high_cnt_d  = '0;
                    rise_seen_d = 1'b0;
                    if (rise) begin
                        // The locking cycle is the first sample of frame 0.
                        state_d     = StRun;
                        locked_d    = 1'b1;
                        frame_cnt_d = {{(N-1){1'b0}}, 1'b1};
                        high_cnt_d  = {{N{1'b0}}, 1'b1};
                        rise_seen_d = 1'b1;
                    end
                end
                StRun: begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    high_cnt_d  = high_cnt_q + level_ext;
                    rise_seen_d = rise_seen_q | rise;
                    if (frame_cnt_q == '0) begin
                        // Boundary cycle: publish the finished frame; this
                        // cycle's sample and rise open the new frame.
                        duty_d      = high_cnt_q[N] ? {M{1'b1}} : high_cnt_q[N-1 -: M];
                        valid_d     = 1'b1;
                        stuck_d     = ~rise_seen_q;
                        high_cnt_d  = level_ext;
                        rise_seen_d = rise;
                        // stuck_q still reflects the previous frame here.
                        if (!rise_seen_q && stuck_q) begin
                            state_d     = StSync;
                            locked_d    = 1'b0;
                            frame_cnt_d = '0;
                            high_cnt_d  = '0;
                            rise_seen_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = StSync;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StSync;
            frame_cnt_q <= '0;
            high_cnt_q  <= '0;
            rise_seen_q <= 1'b0;
            duty_q      <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            stuck_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            high_cnt_q  <= high_cnt_d;
            rise_seen_q <= rise_seen_d;
            duty_q      <= duty_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            stuck_q     <= stuck_d;
        end
    end

    assign duty       = duty_q;
    assign duty_valid = valid_q;
    assign locked     = locked_q;
    assign stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_demod.sv
// Self-checking bench for pwm_demod with N=6, M=4 (64-cycle frames).
// The reference model keeps the sampled input history and evaluates each
// frame as a 64-sample window: duty from the high count, stuck/loss of lock
// from whether any rising edge fell in the window.

module tb_pwm_demod;

    localparam int unsigned N     = 6;
    localparam int unsigned M     = 4;
    localparam int          FRAME = 64;
    localparam int          HMAX  = 8192;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         pwm_in = 1'b0;
    logic [M-1:0] duty;
    logic         duty_valid;
    logic         locked;
    logic         stuck;

    always #5 clk = ~clk;

    pwm_demod #(
        .N (N),
        .M (M)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .pwm_in     (pwm_in),
        .duty       (duty),
        .duty_valid (duty_valid),
        .locked     (locked),
        .stuck      (stuck)
    );

    int total = 0;
    int bad   = 0;

    // Model state: history indexed by clock edge since the last reset release.
    bit           pa [HMAX];
    bit           lv [HMAX];
    bit           ri [HMAX];
    int           k;
    int           m_start;
    logic [M-1:0] m_duty;
    bit           m_valid;
    bit           m_locked;
    bit           m_stuck;

    function automatic bit p_at(int j);
        return (j < 0) ? 1'b0 : pa[j];
    endfunction

    // Level the measurement logic sees at edge j.
    function automatic bit lvl_at(int j);
`ifdef PWM_DEMOD_GLITCH_FILTER_EN
        int c;
        c = int'(p_at(j - 3)) + int'(p_at(j - 4)) + int'(p_at(j - 5));
        return c >= 2;
`else
        return p_at(j - 2);
`endif
    endfunction

    function automatic bit pat(int t, int hi, int ph);
        return ((t + ph) % FRAME) < hi;
    endfunction

    task automatic model_reset();
        k        = 0;
        m_start  = 0;
        m_duty   = '0;
        m_valid  = 1'b0;
        m_locked = 1'b0;
        m_stuck  = 1'b0;
    endtask

    task automatic model_edge(input bit p, input bit e);
        int sum;
        bit fr;
        bit pr;
        if (k >= HMAX) begin
            $display("FAIL history_overflow k=%0d limit=%0d", k, HMAX);
            $fatal(1);
        end
        pa[k] = p;
        lv[k] = lvl_at(k);
        ri[k] = lv[k] & ~lvl_at(k - 1);
        m_valid = 1'b0;
        if (!e) begin
            m_locked = 1'b0;
        end else if (!m_locked) begin
            if (ri[k]) begin
                m_locked = 1'b1;
                m_start  = k;
            end
        end else if ((k - m_start) % FRAME == 0) begin
            sum = 0;
            fr  = 1'b0;
            for (int j = k - FRAME; j < k; j++) begin
                sum += int'(lv[j]);
                fr  |= ri[j];
            end
            pr = 1'b1;
            if (k - 2 * FRAME >= m_start) begin
                pr = 1'b0;
                for (int j = k - 2 * FRAME; j < k - FRAME; j++) pr |= ri[j];
            end
            m_duty  = (sum >= FRAME) ? '1 : M'(sum >> (N - M));
            m_stuck = !fr;
            m_valid = 1'b1;
            if (!fr && !pr) m_locked = 1'b0;
        end
        k++;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic tick(input bit p, input bit e);
        pwm_in = p;
        en     = e;
        @(posedge clk);
        model_edge(p, e);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit any_valid;
        rst_n  = 1'b0;
        en     = 1'b1;
        pwm_in = 1'b0;
        #12;
        total++;
        if ({duty, duty_valid, locked, stuck} !== '0) begin
            bad++;
            $display("FAIL reset_values got duty=%0d v=%0b l=%0b s=%0b want all 0",
                     duty, duty_valid, locked, stuck);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        any_valid = 1'b0;
        for (int t = 0; t < 100; t++) begin
            tick(1'b0, 1'b1);
            any_valid |= duty_valid;
            total++;
            if ({duty, duty_valid, locked, stuck} !== {m_duty, m_valid, m_locked, m_stuck}) begin
                bad++;
                $display("FAIL reset_idle k=%0d got d=%0d v=%0b l=%0b s=%0b want d=%0d v=%0b l=%0b s=%0b",
                         k, duty, duty_valid, locked, stuck, m_duty, m_valid, m_locked, m_stuck);
            end
        end
        total++;
        if (any_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_strobe got valid seen=%0b want 0", any_valid);
        end
    endtask

    task automatic test_quarter_duty();
        int nvalid;
        nvalid = 0;
        for (int t = 0; t < 6 * FRAME; t++) begin
            tick(pat(t, 16, 0), 1'b1);
            total++;
            if ({duty, duty_valid, locked, stuck} !== {m_duty, m_valid, m_locked, m_stuck}) begin
                bad++;
                $display("FAIL quarter k=%0d got d=%0d v=%0b l=%0b s=%0b want d=%0d v=%0b l=%0b s=%0b",
                         k, duty, duty_valid, locked, stuck, m_duty, m_valid, m_locked, m_stuck);
            end
            if (duty_valid) begin
                nvalid++;
                total++;
                if (duty !== 4'd4 || stuck !== 1'b0) begin
                    bad++;
                    $display("FAIL quarter_value got duty=%0d stuck=%0b want duty=4 stuck=0",
                             duty, stuck);
                end
            end
        end
        total++;
        if (nvalid !== 5) begin
            bad++;
            $display("FAIL quarter_strobes got %0d want 5", nvalid);
        end
    endtask

    task automatic test_hold_high();
        for (int t = 0; t < 260; t++) begin
            tick(1'b1, 1'b1);
            total++;
            if ({duty, duty_valid, locked, stuck} !== {m_duty, m_valid, m_locked, m_stuck}) begin
                bad++;
                $display("FAIL hold_high k=%0d got d=%0d v=%0b l=%0b s=%0b want d=%0d v=%0b l=%0b s=%0b",
                         k, duty, duty_valid, locked, stuck, m_duty, m_valid, m_locked, m_stuck);
            end
        end
        total++;
        if ({duty, locked, stuck} !== {4'd15, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL hold_high_end got d=%0d l=%0b s=%0b want d=15 l=0 s=1",
                     duty, locked, stuck);
        end
    endtask

    task automatic test_en_drop();
        bit           drop_valid;
        logic [M-1:0] held;
        for (int t = 0; t < 20; t++) tick(1'b0, 1'b1);
        for (int t = 0; t < 2 * FRAME + 20; t++) begin
            tick(pat(t, 40, 0), 1'b1);
            total++;
            if ({duty, duty_valid, locked, stuck} !== {m_duty, m_valid, m_locked, m_stuck}) begin
                bad++;
                $display("FAIL en_lock k=%0d got d=%0d v=%0b l=%0b s=%0b want d=%0d v=%0b l=%0b s=%0b",
                         k, duty, duty_valid, locked, stuck, m_duty, m_valid, m_locked, m_stuck);
            end
        end
        held = duty;
        drop_valid = 1'b0;
        for (int t = 2 * FRAME + 20; t < 2 * FRAME + 25; t++) begin
            tick(pat(t, 40, 0), 1'b0);
            drop_valid |= duty_valid;
            total++;
            if ({duty, duty_valid, locked, stuck} !== {held, 1'b0, 1'b0, m_stuck}) begin
                bad++;
                $display("FAIL en_drop k=%0d got d=%0d v=%0b l=%0b want d=%0d v=0 l=0",
                         k, duty, duty_valid, locked, held);
            end
        end
        for (int t = 2 * FRAME + 25; t < 2 * FRAME + 325; t++) begin
            tick(pat(t, 40, 0), 1'b1);
            total++;
            if ({duty, duty_valid, locked, stuck} !== {m_duty, m_valid, m_locked, m_stuck}) begin
                bad++;
                $display("FAIL en_relock k=%0d got d=%0d v=%0b l=%0b s=%0b want d=%0d v=%0b l=%0b s=%0b",
                         k, duty, duty_valid, locked, stuck, m_duty, m_valid, m_locked, m_stuck);
            end
        end
        total++;
        if ({duty, locked, drop_valid} !== {4'd10, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL en_relock_end got d=%0d l=%0b dropv=%0b want d=10 l=1 dropv=0",
                     duty, locked, drop_valid);
        end
    endtask

    task automatic test_random();
        int hi;
        int ph;
        int len;
        bit p;
        bit e;
        for (int seg = 0; seg < 30; seg++) begin
            hi  = int'($urandom_range(0, FRAME));
            ph  = int'($urandom_range(0, FRAME - 1));
            len = FRAME * int'($urandom_range(1, 3));
            for (int t = 0; t < len; t++) begin
                p = pat(t, hi, ph);
                if ($urandom_range(0, 49) == 0) p = ~p;
                e = ($urandom_range(0, 199) != 0);
                tick(p, e);
                total++;
                if ({duty, duty_valid, locked, stuck} !== {m_duty, m_valid, m_locked, m_stuck}) begin
                    bad++;
                    $display("FAIL random k=%0d got d=%0d v=%0b l=%0b s=%0b want d=%0d v=%0b l=%0b s=%0b",
                             k, duty, duty_valid, locked, stuck, m_duty, m_valid, m_locked, m_stuck);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        bit early_valid;
        for (int t = 0; t < 20; t++) tick(1'b0, 1'b1);
        for (int t = 0; t < 2 * FRAME + 30; t++) tick(pat(t, 24, 0), 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({duty, duty_valid, locked, stuck} !== '0) begin
            bad++;
            $display("FAIL async_reset got d=%0d v=%0b l=%0b s=%0b want all 0",
                     duty, duty_valid, locked, stuck);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        early_valid = 1'b0;
        for (int t = 0; t < 200; t++) begin
            tick(pat(t, 24, 10), 1'b1);
            if (t < FRAME) early_valid |= duty_valid;
            total++;
            if ({duty, duty_valid, locked, stuck} !== {m_duty, m_valid, m_locked, m_stuck}) begin
                bad++;
                $display("FAIL post_reset k=%0d got d=%0d v=%0b l=%0b s=%0b want d=%0d v=%0b l=%0b s=%0b",
                         k, duty, duty_valid, locked, stuck, m_duty, m_valid, m_locked, m_stuck);
            end
        end
        total++;
        if (early_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_strobe got early valid=%0b want 0", early_valid);
        end
    endtask

    task automatic test_glitch();
        bit ever_locked;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        ever_locked = 1'b0;
        for (int t = 0; t < 300; t++) begin
            tick((t % 20) == 7, 1'b1);
            ever_locked |= locked;
            total++;
            if ({duty, duty_valid, locked, stuck} !== {m_duty, m_valid, m_locked, m_stuck}) begin
                bad++;
                $display("FAIL glitch k=%0d got d=%0d v=%0b l=%0b s=%0b want d=%0d v=%0b l=%0b s=%0b",
                         k, duty, duty_valid, locked, stuck, m_duty, m_valid, m_locked, m_stuck);
            end
        end
        total++;
`ifdef PWM_DEMOD_GLITCH_FILTER_EN
        if ({ever_locked, duty} !== {1'b0, 4'd0}) begin
            bad++;
            $display("FAIL glitch_filtered got locked seen=%0b d=%0d want 0 and 0",
                     ever_locked, duty);
        end
`else
        if (ever_locked !== 1'b1) begin
            bad++;
            $display("FAIL glitch_unfiltered got locked seen=%0b want 1", ever_locked);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_quarter_duty();
        test_hold_high();
        test_en_drop();
        test_random();
        test_async_reset();
        test_glitch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
